// File: rtl/arm_pipe_pkg.sv
// Shared ARM pipeline definitions: ID/EX control bundle, opcode/condition constants,
// and the bubble value that squashed or reset pipeline slots carry.
package arm_pipe_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_EOR  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_CMP  = 4'b1010;
    localparam logic [3:0] OP_ORR  = 4'b1100;
    localparam logic [3:0] OP_MOV  = 4'b1101;
    localparam logic [3:0] OP_NOP  = 4'b1110;

    localparam logic [3:0] COND_AL = 4'b1110;

    // ASCII "NOP", right-justified, used by the optional keyword trace
    localparam logic [47:0] KW_NOP = 48'h0000004E4F50;

    typedef struct packed {
        logic [3:0] opcode;
        logic [1:0] am;
        logic       s_enable;
        logic       load_instr;
        logic       rf_enable;
        logic       size_enable;
        logic       rw_enable;
        logic       mem_enable;
        logic       bl_instr;
        logic       b_instr;
        logic [3:0] cond;
        logic [3:0] rn;
        logic [3:0] rm;
        logic [3:0] rd;
        logic       uses_rm;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t BUBBLE_BUNDLE = '{
        opcode:      OP_NOP,
        am:          2'b00,
        s_enable:    1'b0,
        load_instr:  1'b0,
        rf_enable:   1'b0,
        size_enable: 1'b0,
        rw_enable:   1'b0,
        mem_enable:  1'b0,
        bl_instr:    1'b0,
        b_instr:     1'b0,
        cond:        COND_AL,
        rn:          4'd0,
        rm:          4'd0,
        rd:          4'd0,
        uses_rm:     1'b0
    };

    // An invalid decode slot keeps its control bits for visibility, but must not
    // write the register file, touch memory or redirect the PC.
    function automatic ctrl_bundle_t mask_invalid(input ctrl_bundle_t b, input logic valid);
        ctrl_bundle_t r;
        r = b;
        if (!valid) begin
            r.rf_enable  = 1'b0;
            r.rw_enable  = 1'b0;
            r.mem_enable = 1'b0;
            r.b_instr    = 1'b0;
            r.bl_instr   = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector: a load in EX whose destination is read
// by the instruction currently in ID.
module load_use_detect (
    input  logic       i_ex_valid,
    input  logic       i_ex_load_instr,
    input  logic       i_ex_rf_enable,
    input  logic [3:0] i_ex_rd,
    input  logic       i_id_valid,
    input  logic [3:0] i_id_rn,
    input  logic [3:0] i_id_rm,
    input  logic       i_id_uses_rm,
    output logic       o_hazard
);

    logic w_ex_is_load;
    logic w_rn_match;
    logic w_rm_match;

    assign w_ex_is_load = i_ex_valid & i_ex_load_instr & i_ex_rf_enable;
    assign w_rn_match   = (i_id_rn == i_ex_rd);
    assign w_rm_match   = i_id_uses_rm & (i_id_rm == i_ex_rd);
    assign o_hazard     = w_ex_is_load & i_id_valid & (w_rn_match | w_rm_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with flush/stall/load-use bubble insertion and a
// saturating bubble counter. Optional keyword trace enabled by KEYWORD_TRACE_EN.
module id_ex_stage
    import arm_pipe_pkg::*;
#(
    parameter int BUBBLE_CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    id_valid,
    input  logic [3:0]              id_opcode,
    input  logic [1:0]              id_am,
    input  logic                    id_s_enable,
    input  logic                    id_load_instr,
    input  logic                    id_rf_enable,
    input  logic                    id_size_enable,
    input  logic                    id_rw_enable,
    input  logic                    id_mem_enable,
    input  logic                    id_bl_instr,
    input  logic                    id_b_instr,
    input  logic [3:0]              id_cond,
    input  logic [3:0]              id_rn,
    input  logic [3:0]              id_rm,
    input  logic [3:0]              id_rd,
    input  logic                    id_uses_rm,
`ifdef KEYWORD_TRACE_EN
    input  logic [47:0]             id_keyword,
    output logic [47:0]             ex_keyword,
`endif
    input  logic                    ex_flush,
    input  logic                    ex_stall,
    output logic                    ex_valid,
    output logic [3:0]              ex_opcode,
    output logic [1:0]              ex_am,
    output logic                    ex_s_enable,
    output logic                    ex_load_instr,
    output logic                    ex_rf_enable,
    output logic                    ex_size_enable,
    output logic                    ex_rw_enable,
    output logic                    ex_mem_enable,
    output logic                    ex_bl_instr,
    output logic                    ex_b_instr,
    output logic [3:0]              ex_cond,
    output logic [3:0]              ex_rn,
    output logic [3:0]              ex_rm,
    output logic [3:0]              ex_rd,
    output logic                    ex_uses_rm,
    output logic                    id_hold,
    output logic [BUBBLE_CNT_W-1:0] bubble_cnt
);

    ctrl_bundle_t            r_ex;
    logic                    r_ex_valid;
    logic [BUBBLE_CNT_W-1:0] r_bubble_cnt;

    ctrl_bundle_t            w_id_bundle;
    ctrl_bundle_t            w_load_bundle;
    logic                    w_hazard;
    logic                    w_cnt_sat;

    assign w_id_bundle = '{
        opcode:      id_opcode,
        am:          id_am,
        s_enable:    id_s_enable,
        load_instr:  id_load_instr,
        rf_enable:   id_rf_enable,
        size_enable: id_size_enable,
        rw_enable:   id_rw_enable,
        mem_enable:  id_mem_enable,
        bl_instr:    id_bl_instr,
        b_instr:     id_b_instr,
        cond:        id_cond,
        rn:          id_rn,
        rm:          id_rm,
        rd:          id_rd,
        uses_rm:     id_uses_rm
    };

    assign w_load_bundle = mask_invalid(w_id_bundle, id_valid);

    load_use_detect u_load_use_detect (
        .i_ex_valid      (r_ex_valid),
        .i_ex_load_instr (r_ex.load_instr),
        .i_ex_rf_enable  (r_ex.rf_enable),
        .i_ex_rd         (r_ex.rd),
        .i_id_valid      (id_valid),
        .i_id_rn         (id_rn),
        .i_id_rm         (id_rm),
        .i_id_uses_rm    (id_uses_rm),
        .o_hazard        (w_hazard)
    );

    // A flush squashes whatever ID holds, so upstream must advance, not hold.
    assign id_hold   = (ex_stall | w_hazard) & ~ex_flush;
    assign w_cnt_sat = &r_bubble_cnt;

    // Priority per edge: flush, then stall, then load-use bubble, then normal load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex         <= BUBBLE_BUNDLE;
            r_ex_valid   <= 1'b0;
            r_bubble_cnt <= '0;
        end else if (ex_flush) begin
            r_ex         <= BUBBLE_BUNDLE;
            r_ex_valid   <= 1'b0;
        end else if (ex_stall) begin
            r_ex         <= r_ex;
            r_ex_valid   <= r_ex_valid;
        end else if (w_hazard) begin
            r_ex         <= BUBBLE_BUNDLE;
            r_ex_valid   <= 1'b0;
            if (!w_cnt_sat) begin
                r_bubble_cnt <= r_bubble_cnt + BUBBLE_CNT_W'(1);
            end
        end else begin
            r_ex         <= w_load_bundle;
            r_ex_valid   <= id_valid;
        end
    end

`ifdef KEYWORD_TRACE_EN
    logic [47:0] r_ex_keyword;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_keyword <= KW_NOP;
        end else if (ex_flush) begin
            r_ex_keyword <= KW_NOP;
        end else if (ex_stall) begin
            r_ex_keyword <= r_ex_keyword;
        end else if (w_hazard) begin
            r_ex_keyword <= KW_NOP;
        end else begin
            r_ex_keyword <= id_keyword;
        end
    end

    assign ex_keyword = r_ex_keyword;
`endif

    assign ex_valid       = r_ex_valid;
    assign ex_opcode      = r_ex.opcode;
    assign ex_am          = r_ex.am;
    assign ex_s_enable    = r_ex.s_enable;
    assign ex_load_instr  = r_ex.load_instr;
    assign ex_rf_enable   = r_ex.rf_enable;
    assign ex_size_enable = r_ex.size_enable;
    assign ex_rw_enable   = r_ex.rw_enable;
    assign ex_mem_enable  = r_ex.mem_enable;
    assign ex_bl_instr    = r_ex.bl_instr;
    assign ex_b_instr     = r_ex.b_instr;
    assign ex_cond        = r_ex.cond;
    assign ex_rn          = r_ex.rn;
    assign ex_rm          = r_ex.rm;
    assign ex_rd          = r_ex.rd;
    assign ex_uses_rm     = r_ex.uses_rm;
    assign bubble_cnt     = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a 16-bit counter instance plus a 2-bit counter
// instance sharing all inputs. Optional KEYWORD_TRACE_EN ports are covered when defined.
module tb_id_ex_stage;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [3:0]  id_opcode;
    logic [1:0]  id_am;
    logic        id_s_enable, id_load_instr, id_rf_enable, id_size_enable;
    logic        id_rw_enable, id_mem_enable, id_bl_instr, id_b_instr;
    logic [3:0]  id_cond, id_rn, id_rm, id_rd;
    logic        id_uses_rm;
    logic        ex_flush, ex_stall;

    logic        ex_valid;
    logic [3:0]  ex_opcode;
    logic [1:0]  ex_am;
    logic        ex_s_enable, ex_load_instr, ex_rf_enable, ex_size_enable;
    logic        ex_rw_enable, ex_mem_enable, ex_bl_instr, ex_b_instr;
    logic [3:0]  ex_cond, ex_rn, ex_rm, ex_rd;
    logic        ex_uses_rm;
    logic        id_hold;
    logic [15:0] bubble_cnt;

    logic        s_valid;
    logic [3:0]  s_opcode;
    logic [1:0]  s_am;
    logic        s_s_enable, s_load_instr, s_rf_enable, s_size_enable;
    logic        s_rw_enable, s_mem_enable, s_bl_instr, s_b_instr;
    logic [3:0]  s_cond, s_rn, s_rm, s_rd;
    logic        s_uses_rm;
    logic        s_hold;
    logic [1:0]  s_bubble_cnt;

`ifdef KEYWORD_TRACE_EN
    logic [47:0] id_keyword;
    logic [47:0] ex_keyword;
    logic [47:0] s_keyword;
`endif

    int checks = 0;
    int errors = 0;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    id_ex_stage #(.BUBBLE_CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode), .id_am(id_am),
        .id_s_enable(id_s_enable), .id_load_instr(id_load_instr), .id_rf_enable(id_rf_enable),
        .id_size_enable(id_size_enable), .id_rw_enable(id_rw_enable), .id_mem_enable(id_mem_enable),
        .id_bl_instr(id_bl_instr), .id_b_instr(id_b_instr), .id_cond(id_cond), .id_rn(id_rn),
        .id_rm(id_rm), .id_rd(id_rd), .id_uses_rm(id_uses_rm),
`ifdef KEYWORD_TRACE_EN
        .id_keyword(id_keyword), .ex_keyword(ex_keyword),
`endif
        .ex_flush(ex_flush), .ex_stall(ex_stall), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
        .ex_am(ex_am), .ex_s_enable(ex_s_enable), .ex_load_instr(ex_load_instr),
        .ex_rf_enable(ex_rf_enable), .ex_size_enable(ex_size_enable), .ex_rw_enable(ex_rw_enable),
        .ex_mem_enable(ex_mem_enable), .ex_bl_instr(ex_bl_instr), .ex_b_instr(ex_b_instr),
        .ex_cond(ex_cond), .ex_rn(ex_rn), .ex_rm(ex_rm), .ex_rd(ex_rd), .ex_uses_rm(ex_uses_rm),
        .id_hold(id_hold), .bubble_cnt(bubble_cnt)
    );

    id_ex_stage #(.BUBBLE_CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode), .id_am(id_am),
        .id_s_enable(id_s_enable), .id_load_instr(id_load_instr), .id_rf_enable(id_rf_enable),
        .id_size_enable(id_size_enable), .id_rw_enable(id_rw_enable), .id_mem_enable(id_mem_enable),
        .id_bl_instr(id_bl_instr), .id_b_instr(id_b_instr), .id_cond(id_cond), .id_rn(id_rn),
        .id_rm(id_rm), .id_rd(id_rd), .id_uses_rm(id_uses_rm),
`ifdef KEYWORD_TRACE_EN
        .id_keyword(id_keyword), .ex_keyword(s_keyword),
`endif
        .ex_flush(ex_flush), .ex_stall(ex_stall), .ex_valid(s_valid), .ex_opcode(s_opcode),
        .ex_am(s_am), .ex_s_enable(s_s_enable), .ex_load_instr(s_load_instr),
        .ex_rf_enable(s_rf_enable), .ex_size_enable(s_size_enable), .ex_rw_enable(s_rw_enable),
        .ex_mem_enable(s_mem_enable), .ex_bl_instr(s_bl_instr), .ex_b_instr(s_b_instr),
        .ex_cond(s_cond), .ex_rn(s_rn), .ex_rm(s_rm), .ex_rd(s_rd), .ex_uses_rm(s_uses_rm),
        .id_hold(s_hold), .bubble_cnt(s_bubble_cnt)
    );

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        id_valid = 1'b0; id_opcode = 4'h0; id_am = 2'b00;
        id_s_enable = 1'b0; id_load_instr = 1'b0; id_rf_enable = 1'b0; id_size_enable = 1'b0;
        id_rw_enable = 1'b0; id_mem_enable = 1'b0; id_bl_instr = 1'b0; id_b_instr = 1'b0;
        id_cond = 4'b1110; id_rn = 4'd0; id_rm = 4'd0; id_rd = 4'd0; id_uses_rm = 1'b0;
`ifdef KEYWORD_TRACE_EN
        id_keyword = 48'h0;
`endif
    endtask

    task automatic drive_alu(input logic [3:0] op, input logic [3:0] rn, input logic [3:0] rd);
        drive_idle();
        id_valid = 1'b1; id_opcode = op; id_rn = rn; id_rd = rd; id_rf_enable = 1'b1;
    endtask

    task automatic drive_ldr(input logic [3:0] rd);
        drive_idle();
        id_valid = 1'b1; id_opcode = 4'b0100; id_rn = 4'd1; id_rd = rd;
        id_load_instr = 1'b1; id_rf_enable = 1'b1; id_mem_enable = 1'b1;
    endtask

    initial begin
        logic [1:0] exp_sat [5];
        exp_sat = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        rst_n = 1'b0; ex_flush = 1'b0; ex_stall = 1'b0;
        drive_idle();
        #12;
        check("rst_valid", 48'(ex_valid), 48'h0);
        check("rst_opcode", 48'(ex_opcode), 48'he);
        check("rst_cond", 48'(ex_cond), 48'he);
        check("rst_rd", 48'(ex_rd), 48'h0);
        check("rst_cnt", 48'(bubble_cnt), 48'h0);
        check("rst_hold", 48'(id_hold), 48'h0);
`ifdef KEYWORD_TRACE_EN
        check("rst_kw", ex_keyword, 48'h0000004E4F50);
`endif
        rst_n = 1'b1;

        // normal load, one-cycle latency
        drive_alu(4'b0000, 4'd2, 4'd3);
        #1;
        check("norm_hold", 48'(id_hold), 48'h0);
        tick();
        check("norm_opcode", 48'(ex_opcode), 48'h0);
        check("norm_rd", 48'(ex_rd), 48'h3);
        check("norm_valid", 48'(ex_valid), 48'h1);
        check("norm_rf", 48'(ex_rf_enable), 48'h1);
        check("norm_cond", 48'(ex_cond), 48'he);

        // load-use through Rn
        drive_ldr(4'd5);
        tick();
        check("ldr_in_ex", 48'(ex_load_instr), 48'h1);
        drive_alu(4'b0100, 4'd5, 4'd6);
        #1;
        check("lu_hold", 48'(id_hold), 48'h1);
        tick();
        check("lu_bubble_valid", 48'(ex_valid), 48'h0);
        check("lu_bubble_op", 48'(ex_opcode), 48'he);
        check("lu_cnt", 48'(bubble_cnt), 48'h1);
        check("lu_hold_clear", 48'(id_hold), 48'h0);
        tick();
        check("lu_enter_valid", 48'(ex_valid), 48'h1);
        check("lu_enter_rd", 48'(ex_rd), 48'h6);
        check("lu_enter_rn", 48'(ex_rn), 48'h5);
        check("lu_cnt_same", 48'(bubble_cnt), 48'h1);

        // Rm match only counts when Rm is a source; then flush beats the hazard
        drive_ldr(4'd7);
        tick();
        drive_alu(4'b0000, 4'd1, 4'd8);
        id_rm = 4'd7;
        #1;
        check("rm_unused_hold", 48'(id_hold), 48'h0);
        id_uses_rm = 1'b1;
        #1;
        check("rm_used_hold", 48'(id_hold), 48'h1);
        ex_flush = 1'b1;
        #1;
        check("flush_hold", 48'(id_hold), 48'h0);
        tick();
        ex_flush = 1'b0;
        check("flush_valid", 48'(ex_valid), 48'h0);
        check("flush_cnt", 48'(bubble_cnt), 48'h1);
        check("flush_cond", 48'(ex_cond), 48'he);
        check("flush_rm", 48'(ex_rm), 48'h0);

        // invalid slot: control bits kept, side-effect bits forced low
        drive_idle();
        id_opcode = 4'b0101; id_rd = 4'd9; id_s_enable = 1'b1; id_load_instr = 1'b1;
        id_rf_enable = 1'b1; id_rw_enable = 1'b1; id_mem_enable = 1'b1;
        id_b_instr = 1'b1; id_bl_instr = 1'b1; id_size_enable = 1'b1;
        tick();
        check("inv_valid", 48'(ex_valid), 48'h0);
        check("inv_rf", 48'(ex_rf_enable), 48'h0);
        check("inv_rw", 48'(ex_rw_enable), 48'h0);
        check("inv_mem", 48'(ex_mem_enable), 48'h0);
        check("inv_b", 48'(ex_b_instr), 48'h0);
        check("inv_bl", 48'(ex_bl_instr), 48'h0);
        check("inv_load", 48'(ex_load_instr), 48'h1);
        check("inv_s", 48'(ex_s_enable), 48'h1);
        check("inv_size", 48'(ex_size_enable), 48'h1);
        check("inv_opcode", 48'(ex_opcode), 48'h5);
        check("inv_rd", 48'(ex_rd), 48'h9);

        // stall for three cycles with changing ID contents
        drive_alu(4'b0010, 4'd2, 4'd4);
        id_cond = 4'b0000;
        tick();
        ex_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_alu(4'b1100, 4'd3, 4'(8 + i));
            #1;
            check("stall_hold", 48'(id_hold), 48'h1);
            tick();
            check("stall_opcode", 48'(ex_opcode), 48'h2);
            check("stall_rd", 48'(ex_rd), 48'h4);
            check("stall_cond", 48'(ex_cond), 48'h0);
            check("stall_valid", 48'(ex_valid), 48'h1);
        end
        ex_stall = 1'b0;
        drive_alu(4'b1101, 4'd0, 4'd11);
        #1;
        check("unstall_hold", 48'(id_hold), 48'h0);
        tick();
        check("unstall_opcode", 48'(ex_opcode), 48'hd);
        check("unstall_rd", 48'(ex_rd), 48'hb);

        // async reset while stalled with a pending hazard
        drive_ldr(4'd5);
        tick();
        ex_stall = 1'b1;
        drive_alu(4'b0100, 4'd5, 4'd6);
        tick();
        check("pre_rst_load", 48'(ex_load_instr), 48'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 48'(ex_valid), 48'h0);
        check("arst_cond", 48'(ex_cond), 48'he);
        check("arst_opcode", 48'(ex_opcode), 48'he);
        check("arst_load", 48'(ex_load_instr), 48'h0);
        check("arst_cnt", 48'(bubble_cnt), 48'h0);
        check("arst_hold", 48'(id_hold), 48'h1);
`ifdef KEYWORD_TRACE_EN
        check("arst_kw", ex_keyword, 48'h0000004E4F50);
`endif
        #2;
        rst_n = 1'b1;
        ex_stall = 1'b0;
        drive_alu(4'b0001, 4'd5, 4'd12);
        tick();
        check("post_rst_valid", 48'(ex_valid), 48'h1);
        check("post_rst_rd", 48'(ex_rd), 48'hc);
        check("post_rst_cnt", 48'(bubble_cnt), 48'h0);

        // five hazards: wide counter counts on, narrow one saturates
        for (int i = 0; i < 5; i++) begin
            drive_ldr(4'd5);
            tick();
            drive_alu(4'b0100, 4'd5, 4'd6);
            tick();
            check("sat_cnt2", 48'(s_bubble_cnt), 48'(exp_sat[i]));
            check("sat_cnt16", 48'(bubble_cnt), 48'(i + 1));
        end

`ifdef KEYWORD_TRACE_EN
        drive_alu(4'b0000, 4'd0, 4'd1);
        id_keyword = 48'h000041444421;
        tick();
        check("kw_pass", ex_keyword, 48'h000041444421);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter: BUBBLE_CNT_W, 16, width of the inserted-bubble performance counter.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 id_valid  in  1  decode stage holds a real instruction.
REQ-005 id_opcode  in  4  ALU opcode from control unit.
REQ-006 id_am  in  2  addressing-mode code.
REQ-007 id_s_enable, id_load_instr, id_rf_enable, id_size_enable, id_rw_enable, id_mem_enable, id_bl_instr, id_b_instr  in  1 each  decoded control bits.
REQ-008 id_cond  in  4  instruction condition field [31:28].
REQ-009 id_rn, id_rm, id_rd  in  4 each  register specifiers; id_uses_rm  in  1  Rm is a source operand.
REQ-010 ex_flush  in  1  taken branch in EX; squash ID/EX contents.
REQ-011 ex_stall  in  1  downstream not ready; hold ID/EX contents.
REQ-012 ex_* outputs  out  same widths as id_* (REQ-005..009)  registered copies; ex_valid  out  1.
REQ-013 id_hold  out  1  combinational; upstream (PC, IF/ID) must hold this cycle.
REQ-014 bubble_cnt  out  BUBBLE_CNT_W  count of load-use bubbles inserted.

Function
REQ-015 Load-use hazard SHALL be: ex_valid & ex_load_instr & ex_rf_enable & id_valid & (id_rn==ex_rd | (id_uses_rm & id_rm==ex_rd)).
REQ-016 Per-edge priority SHALL be: flush > ex_stall > hazard > normal load.
REQ-017 Flush: register SHALL load a bubble (ex_valid=0, all control bits 0, ex_opcode=4'b1110, ex_cond=4'b1110, specifiers 0) next edge; bubble_cnt unchanged.
REQ-018 ex_stall without flush: all ex_* registers and bubble_cnt SHALL hold.
REQ-019 Hazard without flush/stall: register SHALL load a bubble and bubble_cnt SHALL increment by 1.
REQ-020 Normal: every ex_* SHALL equal its id_* counterpart one cycle later; ex_valid = id_valid; latency exactly 1 cycle.
REQ-021 When id_valid=0, control bits SHALL still be registered but ex_valid=0 and ex_rf_enable, ex_rw_enable, ex_mem_enable, ex_b_instr, ex_bl_instr forced 0.
REQ-022 id_hold SHALL be (ex_stall | hazard) & ~ex_flush.
REQ-023 bubble_cnt SHALL saturate at all-ones; no wrap.
REQ-024 Hazard persists at most one cycle per load: after the bubble, ex_load_instr=0 so hazard clears.

Reset
REQ-025 rst_n low SHALL immediately force the bubble value of REQ-017 on all ex_* outputs, bubble_cnt=0; id_hold follows REQ-022 from reset state (0 unless ex_stall).
REQ-026 Reset asserted mid-stall or mid-hazard SHALL discard held contents; first edge after release performs a normal load.

Configuration
REQ-027 Macro KEYWORD_TRACE_EN defined: ports id_keyword in 48 and ex_keyword out 48 SHALL exist, pipelined per REQ-016..020; bubbles and reset load ASCII "NOP" right-justified (48'h0000004E4F50).
REQ-028 KEYWORD_TRACE_EN undefined: those ports and registers SHALL be absent; all other behaviour identical.

Structure
REQ-029 Shared package arm_pipe_pkg SHALL hold: control-bundle typedef, opcode constants (NOP opcode 4'b1110), COND_AL=4'b1110, KW_NOP constant, bubble bundle constant.
REQ-030 One sub-module load_use_detect (combinational, REQ-015) SHALL be instantiated; everything else inline.

Verification
REQ-031 Normal: id_valid=1, id_opcode=4'b0000, id_rd=3, id_rf_enable=1 -> next cycle ex_opcode=0000, ex_rd=3, ex_valid=1, id_hold=0.
REQ-032 Load-use: EX holds LDR rd=5 (ex_load_instr=1, ex_rf_enable=1), ID has rn=5 -> id_hold=1 same cycle, next cycle ex_valid=0, bubble_cnt 0->1, following cycle ID instruction enters EX.
REQ-033 Flush vs hazard: hazard and ex_flush both 1 -> ex_valid=0, bubble_cnt unchanged, id_hold=0.
REQ-034 Stall: ex_stall=1 for 3 cycles with changing id_* -> ex_* constant, id_hold=1 throughout, resumes with current id_* on release.
REQ-035 Saturation: BUBBLE_CNT_W=2, force 5 hazards -> bubble_cnt 1,2,3,3,3.
REQ-036 Async reset: drop rst_n between edges during stall -> ex_valid=0, ex_cond=1110, bubble_cnt=0 immediately; with KEYWORD_TRACE_EN, ex_keyword=48'h0000004E4F50.
